// File: rtl/signed_sub_pkg.sv
// Shared constants and slice types for the pipelined signed subtractor.
package signed_sub_pkg;

    localparam int W_DEF     = 16;
    localparam int CHUNK_DEF = 4;

    typedef struct packed {
        logic                 carry;
        logic [CHUNK_DEF-1:0] sum;
    } slice_t;

endpackage

// File: rtl/signed_sub_with_overflow_pipe_if.sv
// Valid/ready stream bundle between producer, subtractor and consumer.
interface signed_sub_with_overflow_pipe_if
    import signed_sub_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_a;
    logic [W-1:0] up_b;
    logic         down_valid;
    logic         down_ready;
    logic [W-1:0] down_diff;
    logic         down_overflow;

    modport master (
        output up_valid,
        output up_a,
        output up_b,
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  down_diff,
        input  down_overflow
    );

    modport slave (
        input  up_valid,
        input  up_a,
        input  up_b,
        input  down_ready,
        output up_ready,
        output down_valid,
        output down_diff,
        output down_overflow
    );

endinterface

// File: rtl/signed_sub_chunk_stage.sv
// One carry-chain slice: adds slice IDX of a and ~b, registers carry,
// skewed operands, accumulated result and the valid bit.
module signed_sub_chunk_stage #(
    parameter int W     = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         in_valid,
    input  logic         in_carry,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_nb,
    input  logic [W-1:0] in_res,
    input  logic         in_sa,
    input  logic         in_sb,
    output logic         out_valid,
    output logic         out_carry,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_nb,
    output logic [W-1:0] out_res,
    output logic         out_sa,
    output logic         out_sb
);

    typedef struct packed {
        logic             carry;
        logic [CHUNK-1:0] sum;
    } chunk_sum_t;

    chunk_sum_t   s;
    logic [W-1:0] res_next;

    always_comb begin
        s = chunk_sum_t'({1'b0, in_a[IDX*CHUNK +: CHUNK]}
                         + {1'b0, in_nb[IDX*CHUNK +: CHUNK]}
                         + (CHUNK+1)'(in_carry));
        res_next = in_res;
        res_next[IDX*CHUNK +: CHUNK] = s.sum;
    end

    // Data is cleared on reset so the result port reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_a     <= '0;
            out_nb    <= '0;
            out_res   <= '0;
            out_sa    <= 1'b0;
            out_sb    <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_carry <= s.carry;
            out_a     <= in_a;
            out_nb    <= in_nb;
            out_res   <= res_next;
            out_sa    <= in_sa;
            out_sb    <= in_sb;
        end
    end

endmodule

// File: rtl/signed_sub_with_overflow_pipe.sv
// Pipelined a - b with signed overflow, one CHUNK-bit slice per stage.
// Optional saturation of the result on overflow: SIGNED_SUB_SATURATE_EN.
module signed_sub_with_overflow_pipe
    import signed_sub_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input logic clk,
    input logic rst,
    signed_sub_with_overflow_pipe_if.slave bus
);

    localparam int STAGES = W / CHUNK;

    logic         advance;
    logic [W-1:0] diff;
    logic         ovf;

    logic [STAGES:0] v;
    logic [STAGES:0] c;
    logic [STAGES:0] sa;
    logic [STAGES:0] sb;
    logic [W-1:0]    a_p   [STAGES+1];
    logic [W-1:0]    nb_p  [STAGES+1];
    logic [W-1:0]    res_p [STAGES+1];

    assign advance      = !v[STAGES] || bus.down_ready;
    assign bus.up_ready = advance;

    // Stage 0 sees raw operands; carry-in 1 completes the negation of b.
    assign v[0]     = bus.up_valid;
    assign c[0]     = 1'b1;
    assign a_p[0]   = bus.up_a;
    assign nb_p[0]  = ~bus.up_b;
    assign res_p[0] = '0;
    assign sa[0]    = bus.up_a[W-1];
    assign sb[0]    = bus.up_b[W-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        signed_sub_chunk_stage #(
            .W     (W),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_valid  (v[k]),
            .in_carry  (c[k]),
            .in_a      (a_p[k]),
            .in_nb     (nb_p[k]),
            .in_res    (res_p[k]),
            .in_sa     (sa[k]),
            .in_sb     (sb[k]),
            .out_valid (v[k+1]),
            .out_carry (c[k+1]),
            .out_a     (a_p[k+1]),
            .out_nb    (nb_p[k+1]),
            .out_res   (res_p[k+1]),
            .out_sa    (sa[k+1]),
            .out_sb    (sb[k+1])
        );
    end

    assign diff = res_p[STAGES];
    assign ovf  = (sa[STAGES] != sb[STAGES]) && (diff[W-1] != sa[STAGES]);

    assign bus.down_valid    = v[STAGES];
    assign bus.down_overflow = ovf;

`ifdef SIGNED_SUB_SATURATE_EN
    always_comb begin
        bus.down_diff = diff;
        if (ovf) begin
            bus.down_diff = sa[STAGES] ? {1'b1, {(W-1){1'b0}}}
                                       : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign bus.down_diff = diff;
`endif

endmodule
